// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared state encoding and UD offset constants for the
//               digit-lookup sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // 2'd3 is unused and decodes to IDLE in the controller
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] UD_CUR   = 2'b00;
    localparam logic [1:0] UD_PREV  = 2'b01;
    localparam logic [1:0] UD_NEXT  = 2'b10;
    localparam logic [1:0] UD_BLANK = 2'b11;

    function automatic logic [1:0] peek_to_ud(input logic [1:0] peek);
        case (peek)
            2'b01:   return UD_PREV;
            2'b10:   return UD_NEXT;
            default: return UD_CUR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sequence_controller_if
// Description : Control inputs and decoder-facing outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sequence_controller_if #(
    parameter int POS_W = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             step;
    logic             dir;
    logic [1:0]       peek;
    logic [POS_W-1:0] R;
    logic [1:0]       UD;
    logic             busy;
    logic             wrap;

    modport master (
        output start, stop, pause, step, dir, peek,
        input  R, UD, busy, wrap
    );

    modport slave (
        input  start, stop, pause, step, dir, peek,
        output R, UD, busy, wrap
    );
endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Counts 0..TICK_DIV-1 while enabled; tick marks the last count.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding when en is low lets a pause resume from the same phase
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/sequence_controller.sv
`default_nettype none
// ============================================================================
// Module      : sequence_controller
// Description : Steps decoder position R through 0..LAST (up/down, wrapping)
//               with run/pause/single-step control and prev/next peek on UD.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_controller
    import seq_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int LAST     = 8,
    parameter int POS_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sequence_controller_if.slave  bus
);
    localparam logic [POS_W-1:0] LAST_P = POS_W'(LAST);

    state_t           state_q, state_d;
    logic [POS_W-1:0] r_q, r_d;
    logic [1:0]       ud_q, ud_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;

    state_t           cur_state;
    logic             in_run;
    logic             in_pause;
    logic             presc_en;
    logic             presc_clr;
    logic             tick;
    logic             advance;

    assign cur_state = (state_q == ST_RUN || state_q == ST_PAUSE) ? state_q : ST_IDLE;
    assign in_run    = (cur_state == ST_RUN);
    assign in_pause  = (cur_state == ST_PAUSE);

    // Higher-priority commands in RUN freeze the prescaler for that cycle
    assign presc_clr = bus.stop || bus.start;
    assign presc_en  = in_run && !bus.stop && !bus.start && !bus.pause;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = cur_state;
        r_d     = r_q;
        wrap_d  = 1'b0;
        advance = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
            r_d     = '0;
        end else if (bus.start) begin
            state_d = ST_RUN;
            r_d     = bus.dir ? LAST_P : '0;
        end else if (bus.pause && in_run) begin
            state_d = ST_PAUSE;
        end else if (bus.pause && in_pause) begin
            state_d = ST_RUN;
        end else if (bus.step && in_pause) begin
            advance = 1'b1;
        end else if (tick) begin
            advance = 1'b1;
        end

        if (advance) begin
            if (!bus.dir) begin
                if (r_q == LAST_P) begin
                    r_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                if (r_q == '0) begin
                    r_d    = LAST_P;
                    wrap_d = 1'b1;
                end else begin
                    r_d = r_q - 1'b1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
        ud_d   = busy_d ? peek_to_ud(bus.peek) : UD_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            ud_q    <= UD_BLANK;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ud_q    <= ud_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.R    = r_q;
    assign bus.UD   = ud_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;

endmodule
`default_nettype wire
